// File: rtl/scan_host_pkg.sv
// Shared types for the scan host: FSM state enum, chain control encodings,
// and small helpers used by the controller and its clock generator.
package scan_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] CTL_IDLE    = 2'b00;
  localparam logic [1:0] CTL_SHIFT   = 2'b01;
  localparam logic [1:0] CTL_CAPTURE = 2'b10;
  localparam logic [1:0] CTL_UPDATE  = 2'b11;

  // Chain control code presented while the FSM sits in a given state.
  function automatic logic [1:0] ctl_of(input state_t s);
    case (s)
      ST_CAPTURE: return CTL_CAPTURE;
      ST_SHIFT:   return CTL_SHIFT;
      ST_UPDATE:  return CTL_UPDATE;
      default:    return CTL_IDLE;
    endcase
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_clk_gen.sv
// Scan clock divider: while enabled, scan_clk is low for CLK_DIV cycles and
// then high for CLK_DIV cycles. rise/fall are high in the cycle whose closing
// edge will drive scan_clk high/low, so the FSM can act on that same edge.
module scan_clk_gen
  import scan_host_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scan_clk,
  output logic rise,
  output logic fall
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          phase_end;

  assign phase_end = en && (div_cnt == DIV_LAST);
  assign rise      = phase_end && !scan_clk;
  assign fall      = phase_end && scan_clk;

  // Count half-period cycles and toggle scan_clk at the end of each; idle low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_clk <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      scan_clk <= 1'b0;
    end else if (phase_end) begin
      div_cnt  <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/scan_host_ctrl.sv
// Scan chain host controller. Accepts one frame per command, optionally runs a
// CAPTURE period, shifts the frame out LSB-first while collecting the chain's
// output, optionally runs an UPDATE period, then offers the collected frame.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds valid and data stable until that edge.
module scan_host_ctrl
  import scan_host_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_capture,
  input  logic                 cmd_update,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 scan_clk,
  output logic                 scan_out,
  input  logic                 scan_in,
  output logic [1:0]           scan_state_ctl_signal,
  output state_t               dbg_state
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] tx_q;
  logic [CHAIN_LEN-1:0] rx_q;
  logic                 upd_q;
  logic [BW-1:0]        bit_cnt;
  logic                 gen_en;
  logic                 clk_rise;
  logic                 clk_fall;
  logic                 accept;
  logic                 last_bit;

  assign cmd_ready             = (state_q == ST_IDLE);
  assign accept                = cmd_valid && cmd_ready;
  assign last_bit              = (bit_cnt == BIT_LAST);
  assign gen_en                = (state_q == ST_CAPTURE) || (state_q == ST_SHIFT) ||
                                 (state_q == ST_UPDATE);
  assign scan_state_ctl_signal = ctl_of(state_q);
  assign dbg_state             = state_q;

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (gen_en),
    .scan_clk (scan_clk),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: busy states advance only at the end of a scan period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = cmd_capture ? ST_CAPTURE : ST_SHIFT;
      ST_CAPTURE: if (clk_fall) state_d = ST_SHIFT;
      ST_SHIFT:   if (clk_fall && last_bit) state_d = upd_q ? ST_UPDATE : ST_RESP;
      ST_UPDATE:  if (clk_fall) state_d = ST_RESP;
      ST_RESP:    if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outbound frame, bit counter and scan_out, all moved on low-phase entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q     <= '0;
      upd_q    <= 1'b0;
      bit_cnt  <= '0;
      scan_out <= 1'b0;
    end else if (accept) begin
      tx_q     <= cmd_data;
      upd_q    <= cmd_update;
      bit_cnt  <= '0;
      scan_out <= cmd_capture ? 1'b0 : cmd_data[0];
    end else if (state_q == ST_CAPTURE && clk_fall) begin
      scan_out <= tx_q[0];
    end else if (state_q == ST_SHIFT && clk_fall) begin
      bit_cnt  <= bit_cnt + BW'(1);
      tx_q     <= tx_q >> 1;
      scan_out <= last_bit ? 1'b0 : tx_q[1];
    end
  end

  // Inbound frame: sample scan_in as scan_clk rises, filling from the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rx_q <= '0;
    else if (state_q == ST_SHIFT && clk_rise) rx_q <= {scan_in, rx_q[CHAIN_LEN-1:1]};
  end

  // Response: raise valid one cycle into RESP, drop it on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state_q == ST_RESP && !rsp_valid) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rx_q;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_host_ctrl.sv
// Bench for scan_host_ctrl: DUT A (CHAIN_LEN=8, CLK_DIV=2) talks to a
// behavioural scan chain; DUT B (CHAIN_LEN=8, CLK_DIV=1) is looped back.
module tb_scan_host_ctrl;
  import scan_host_pkg::*;

  localparam int N  = 8;
  localparam int DA = 2;
  localparam int DB = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A signals
  logic         cmd_valid_a = 1'b0, cmd_capture_a = 1'b0, cmd_update_a = 1'b0;
  logic         rsp_ready_a = 1'b0;
  logic [N-1:0] cmd_data_a = '0;
  logic         cmd_ready_a, rsp_valid_a, scan_clk_a, scan_out_a, scan_in_a;
  logic [N-1:0] rsp_data_a;
  logic [1:0]   ctl_a;
  state_t       dbg_a;

  // DUT B signals
  logic         cmd_valid_b = 1'b0, cmd_capture_b = 1'b0, cmd_update_b = 1'b0;
  logic         rsp_ready_b = 1'b0;
  logic [N-1:0] cmd_data_b = '0;
  logic         cmd_ready_b, rsp_valid_b, scan_clk_b, scan_out_b, scan_in_b;
  logic [N-1:0] rsp_data_b;
  logic [1:0]   ctl_b;
  state_t       dbg_b;

  scan_host_ctrl #(.CHAIN_LEN(N), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_capture(cmd_capture_a), .cmd_update(cmd_update_a), .cmd_data(cmd_data_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
    .scan_clk(scan_clk_a), .scan_out(scan_out_a), .scan_in(scan_in_a),
    .scan_state_ctl_signal(ctl_a), .dbg_state(dbg_a)
  );

  scan_host_ctrl #(.CHAIN_LEN(N), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_capture(cmd_capture_b), .cmd_update(cmd_update_b), .cmd_data(cmd_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .scan_clk(scan_clk_b), .scan_out(scan_out_b), .scan_in(scan_in_b),
    .scan_state_ctl_signal(ctl_b), .dbg_state(dbg_b)
  );

  assign scan_in_b = scan_out_b;

  // Behavioural scan chain for DUT A: shifts toward bit 0 on scan_clk rise in
  // SHIFT, loads chain_cap on scan_clk rise in CAPTURE.
  logic [N-1:0] chain_q = 8'h00;
  logic [N-1:0] chain_cap = 8'h00;
  assign scan_in_a = chain_q[0];
  always @(posedge scan_clk_a) begin
    if (ctl_a == 2'b01)      chain_q <= {scan_out_a, chain_q[N-1:1]};
    else if (ctl_a == 2'b10) chain_q <= chain_cap;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready_a, rsp_valid_a, scan_clk_a, scan_out_a, ctl_a} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctl_a: got %b exp %b",
               {cmd_ready_a, rsp_valid_a, scan_clk_a, scan_out_a, ctl_a}, 6'b100000);
    end
    checks++;
    if (rsp_data_a !== '0 || dbg_a !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_data_a: got data %h state %0d exp 00 / 0", rsp_data_a, dbg_a);
    end
    checks++;
    if ({cmd_ready_b, rsp_valid_b, scan_clk_b, scan_out_b, ctl_b} !== 6'b100000 ||
        rsp_data_b !== '0) begin
      errors++;
      $display("FAIL reset_b: got %b data %h exp 100000 data 00",
               {cmd_ready_b, rsp_valid_b, scan_clk_b, scan_out_b, ctl_b}, rsp_data_b);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One full command on DUT A, checked cycle by cycle against the period model.
  task automatic run_cmd(input logic [N-1:0] data, input logic cap, input logic upd,
                         input int hold, input logic noise);
    int p;
    int last;
    int k;
    int s;
    logic [N-1:0] exp_rsp;
    logic [1:0]   e_ctl;
    logic         e_so;
    logic         e_sc;
    p    = N + int'(cap) + int'(upd);
    last = 2 * DA * p;
    exp_q.push_back(cap ? chain_cap : chain_q);
    cmd_data_a = data; cmd_capture_a = cap; cmd_update_a = upd; cmd_valid_a = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      k = n / (2 * DA);
      s = k - int'(cap);
      e_sc = (n < last) && ((n % (2 * DA)) >= DA);
      e_ctl = 2'b00;
      e_so  = 1'b0;
      if (n < last) begin
        if (cap && k == 0)         e_ctl = 2'b10;
        else if (s >= 0 && s < N) begin
          e_ctl = 2'b01;
          e_so  = data[s];
        end else                   e_ctl = 2'b11;
      end
      checks++;
      if ({ctl_a, scan_out_a, scan_clk_a, rsp_valid_a, cmd_ready_a} !== {e_ctl, e_so, e_sc, 2'b00}) begin
        errors++;
        $display("FAIL busy_cycle %0d: got ctl/so/sc/rv/cr %b exp %b", n,
                 {ctl_a, scan_out_a, scan_clk_a, rsp_valid_a, cmd_ready_a}, {e_ctl, e_so, e_sc, 2'b00});
      end
      if (noise) begin
        cmd_valid_a   = 1'($urandom_range(0, 1));
        cmd_data_a    = N'($urandom);
        cmd_capture_a = 1'($urandom_range(0, 1));
        cmd_update_a  = 1'($urandom_range(0, 1));
      end
    end
    cmd_valid_a = 1'b0;
    @(posedge clk);
    #1;
    exp_rsp = exp_q.pop_front();
    checks++;
    if (rsp_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid_time: got %b exp 1 at cycle %0d", rsp_valid_a, last + 1);
    end
    checks++;
    if (rsp_data_a !== exp_rsp) begin
      errors++;
      $display("FAIL rsp_data: got %h exp %h", rsp_data_a, exp_rsp);
    end
    for (int h = 0; h < hold; h++) begin
      cmd_valid_a = (h == hold / 2);
      cmd_data_a  = N'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid_a, cmd_ready_a, ctl_a, rsp_data_a} !== {1'b1, 1'b0, 2'b00, exp_rsp}) begin
        errors++;
        $display("FAIL rsp_hold %0d: got rv/cr/ctl/data %b/%b/%b/%h exp 1/0/00/%h",
                 h, rsp_valid_a, cmd_ready_a, ctl_a, rsp_data_a, exp_rsp);
      end
    end
    cmd_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_a = 1'b0;
    checks++;
    if ({rsp_valid_a, cmd_ready_a, ctl_a, rsp_data_a} !== {1'b0, 1'b1, 2'b00, exp_rsp}) begin
      errors++;
      $display("FAIL rsp_done: got rv/cr/ctl/data %b/%b/%b/%h exp 0/1/00/%h",
               rsp_valid_a, cmd_ready_a, ctl_a, rsp_data_a, exp_rsp);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready_a, ctl_a, scan_clk_a} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after: got cr/ctl/sc %b exp 1000", {cmd_ready_a, ctl_a, scan_clk_a});
    end
  endtask

  task automatic test_shift_update();
    run_cmd(8'hA5, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_capture();
    chain_cap = 8'h3C;
    run_cmd(8'($urandom), 1'b1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_hold();
    run_cmd(8'($urandom), 1'b0, 1'b0, 10, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      chain_cap = 8'($urandom);
      run_cmd(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] data;
    data = 8'($urandom);
    cmd_data_a = data; cmd_capture_a = 1'b0; cmd_update_a = 1'b1; cmd_valid_a = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    repeat (3 * 2 * DA) @(posedge clk);
    #1;
    checks++;
    if ({ctl_a, scan_out_a} !== {2'b01, data[3]}) begin
      errors++;
      $display("FAIL abort_pre: got ctl/so %b exp %b", {ctl_a, scan_out_a}, {2'b01, data[3]});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({scan_clk_a, ctl_a, rsp_valid_a, cmd_ready_a, scan_out_a} !== 6'b000010) begin
      errors++;
      $display("FAIL abort_rst: got sc/ctl/rv/cr/so %b exp 000010",
               {scan_clk_a, ctl_a, rsp_valid_a, cmd_ready_a, scan_out_a});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready_a, ctl_a, rsp_valid_a} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_release: got cr/ctl/rv %b exp 1000", {cmd_ready_a, ctl_a, rsp_valid_a});
    end
    run_cmd(8'h5A, 1'b0, 1'b0, 3, 1'b0);
  endtask

  task automatic test_loopback();
    logic [N-1:0] data;
    for (int i = 0; i < 2; i++) begin
      data = (i == 0) ? 8'h81 : 8'($urandom);
      cmd_data_b = data; cmd_valid_b = 1'b1; rsp_ready_b = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid_b = 1'b0;
      for (int n = 0; n <= 2 * DB * N; n++) begin
        if (n > 0) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if ({scan_clk_b, rsp_valid_b} !== {1'((n < 2 * DB * N) && (n % 2 == 1)), 1'b0}) begin
          errors++;
          $display("FAIL loop_clk %0d: got sc/rv %b%b exp %b0", n, scan_clk_b, rsp_valid_b,
                   1'((n < 2 * DB * N) && (n % 2 == 1)));
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid_b, rsp_data_b} !== {1'b1, data}) begin
        errors++;
        $display("FAIL loop_rsp: got rv %b data %h exp 1 data %h", rsp_valid_b, rsp_data_b, data);
      end
      @(posedge clk);
      #1;
      rsp_ready_b = 1'b0;
      checks++;
      if ({rsp_valid_b, cmd_ready_b, rsp_data_b} !== {1'b0, 1'b1, data}) begin
        errors++;
        $display("FAIL loop_done: got rv/cr %b%b data %h exp 01 data %h",
                 rsp_valid_b, cmd_ready_b, rsp_data_b, data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_update();
    test_capture();
    test_hold();
    test_random();
    test_reset_abort();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
